// File: rtl/uart_pkg.sv
// uart_pkg: shared UART frame constants, parity types and FSM state encoding
package uart_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int MIN_PRESCALE = 4;
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD = 1'b1;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_t;
endpackage

// File: rtl/uart_tx_parity_calc.sv
// uart_tx_parity_calc: parity bit of a latched byte; in data, par_typ; out par_bit
module uart_tx_parity_calc import uart_pkg::*; #(
  parameter int W = DATA_WIDTH
) (
  input  logic [W-1:0] data,
  input  logic         par_typ,
  output logic         par_bit
);
  assign par_bit = (^data) ^ (par_typ == PAR_ODD);
endmodule

// File: rtl/uart_tx.sv
// uart_tx: UART serialiser; in clk, rest (async low), p_data, data_valid, par_en, par_typ, prescale; out tx_out, busy; UART_TX_TWO_STOP_EN selects two stop bits
module uart_tx #(
  parameter int DATA_WIDTH = uart_pkg::DATA_WIDTH,
  parameter int PRESCALE_W = 5,
  parameter int MIN_PRESCALE = uart_pkg::MIN_PRESCALE
) (
  input  logic                  clk,
  input  logic                  rest,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  input  logic                  par_en,
  input  logic                  par_typ,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tx_out,
  output logic                  busy
);
  import uart_pkg::*;
  localparam int BW = $clog2(DATA_WIDTH);
`ifdef UART_TX_TWO_STOP_EN
  localparam int STOP_BITS = 2;
`else
  localparam int STOP_BITS = 1;
`endif
  uart_state_t state, next;
  logic [DATA_WIDTH-1:0] shadow;
  logic [PRESCALE_W-1:0] p_lat, tick_cnt;
  logic [BW-1:0] bit_cnt;
  logic s_par_en, s_par_typ, par_bit, accept, tick_end, last;
  uart_tx_parity_calc #(.W(DATA_WIDTH)) u_par (.data(shadow), .par_typ(s_par_typ), .par_bit(par_bit));
  assign accept = state == IDLE && data_valid;
  assign tick_end = tick_cnt == p_lat - 1'b1;
  assign last = bit_cnt == (state == STOP ? BW'(STOP_BITS - 1) : BW'(DATA_WIDTH - 1));
  always_comb begin
    next = state;
    if (accept) next = START;
    else if (tick_end && state != IDLE)
      next = state == START ? DATA :
             state == DATA ? (last ? (s_par_en ? PARITY : STOP) : DATA) :
             state == PARITY ? STOP :
             last ? IDLE : STOP;
  end
  always_ff @(posedge clk or negedge rest) begin
    if (!rest) state <= IDLE;
    else state <= next;
  end
  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      tick_cnt <= '0;
      bit_cnt <= '0;
      shadow <= '0;
      s_par_en <= 1'b0;
      s_par_typ <= 1'b0;
      p_lat <= '0;
      tx_out <= 1'b1;
      busy <= 1'b0;
    end else begin
      tick_cnt <= state == IDLE || tick_end ? '0 : tick_cnt + 1'b1;
      bit_cnt <= next != state ? '0 : tick_end ? bit_cnt + 1'b1 : bit_cnt;
      if (accept) begin
        shadow <= p_data;
        s_par_en <= par_en;
        s_par_typ <= par_typ;
        p_lat <= prescale < PRESCALE_W'(MIN_PRESCALE) ? PRESCALE_W'(MIN_PRESCALE) : prescale;
      end
      tx_out <= state == START ? 1'b0 : state == DATA ? shadow[bit_cnt] : state == PARITY ? par_bit : 1'b1;
      busy <= state != IDLE;
    end
  end
endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART transmitter; transmit-side counterpart of the UART receive path. Shares its frame format and its prescale/parity configuration.
- Accepts a parallel byte with a single-cycle valid strobe and serialises it on `tx_out`.
  - Frame: start bit, 8 data bits LSB first, optional parity bit, stop bit.
  - Each bit is held for `prescale` clock cycles.
- Sits between the system-side TX FIFO/controller and the serial line, on the UART clock domain.

Parameters:
- DATA_WIDTH, 8, data bits per frame.
- PRESCALE_W, 5, width of the prescale input.
- MIN_PRESCALE, 4, smallest honoured bit period; smaller `prescale` values are clamped to this.

Ports:
- clk  input  1  UART clock. All logic is rising-edge.
- rest  input  1  asynchronous active-low reset.
- p_data  input  DATA_WIDTH  byte to transmit; sampled only on acceptance.
- data_valid  input  1  one-cycle request to send `p_data`.
- par_en  input  1  1 = insert parity bit; sampled on acceptance.
- par_typ  input  1  0 = even parity, 1 = odd parity; sampled on acceptance.
- prescale  input  PRESCALE_W  clocks per bit; sampled on acceptance.
- tx_out  output  1  serial line. Registered. Idle level is 1.
- busy  output  1  1 while a frame is in progress. Registered.

Behaviour:
- Reset (`rest` = 0, asynchronous):
  - `tx_out` = 1, `busy` = 0, state = IDLE, all counters = 0, shadow registers = 0.
  - Reset asserted mid-frame aborts the frame immediately. The line returns high; no partial frame resumes after reset.
- Acceptance:
  - A request is accepted when state = IDLE and `data_valid` = 1 on a rising edge.
  - On acceptance, `p_data`, `par_en`, `par_typ` and the clamped `prescale` are latched into shadow registers. Input changes during a frame have no effect.
  - `data_valid` while `busy` = 1 is ignored: not queued, no error.
- Latency:
  - Acceptance at edge N gives `tx_out` = 0 and `busy` = 1 from edge N+1.
- States:
  - IDLE: `tx_out` = 1. Go to START on acceptance.
  - START: `tx_out` = 0 for P cycles, where P is the latched prescale. Then go to DATA.
  - DATA: `tx_out` = `shadow[bit_cnt]`, `bit_cnt` counting 0..7, each bit held for P cycles. After bit 7, go to PARITY if `par_en`, else STOP.
  - PARITY: `tx_out` = XOR of the 8 data bits XOR `par_typ`, for P cycles. Then go to STOP.
  - STOP: `tx_out` = 1 for P cycles. Then go to IDLE and `busy` = 0.
- Timing counter:
  - `tick_cnt` has PRESCALE_W bits; it counts 0..P-1 and wraps to 0 at each bit boundary.
  - `bit_cnt` has 3 bits and clears on entry to DATA.
- Frame length:
  - (10 + `par_en`) × P cycles from the first low edge to `busy` falling.
- Back-to-back:
  - `busy` falls at the end of the last stop cycle. The edge at which `busy` = 0 may accept a new request.
  - The minimum gap between frames is therefore exactly one idle-high cycle.
- Clamp:
  - `prescale` < MIN_PRESCALE (including 0) is latched as MIN_PRESCALE.
  - `prescale` = 31 is honoured as 31.

Optional Feature:
- Macro: UART_TX_TWO_STOP_EN.
- Defined:
  - STOP lasts 2×P cycles (two stop bits).
  - Frame length is (11 + `par_en`) × P cycles.
- Undefined:
  - A single stop bit, as described in Behaviour.
- Port list is identical in both builds.

Decomposition:
- Shared package/include file `uart_pkg`:
  - state encodings IDLE/START/DATA/PARITY/STOP;
  - parity-type constants PAR_EVEN = 0, PAR_ODD = 1;
  - DATA_WIDTH and MIN_PRESCALE defaults.
  - The receiver path reuses the same constants.
- One natural sub-module, `uart_tx_parity_calc`:
  - combinational parity from the latched byte and `par_typ`;
  - mirrors the receive-side parity check.
- Tick/bit counters and the FSM stay in `uart_tx`.

Test Plan:
1. Reset, then `prescale` = 8, `par_en` = 0, `p_data` = 0xA5, one-cycle `data_valid`.
   - `tx_out` reads 0,1,0,1,0,0,1,0,1,1, one bit per 8 cycles.
   - `busy` is high for exactly 80 cycles.
2. `prescale` = 16, `par_en` = 1, `par_typ` = 0, `p_data` = 0x07.
   - Parity bit = 1; frame is 176 cycles.
   - Repeat with `par_typ` = 1: parity bit = 0.
3. Hold `data_valid` high continuously with `p_data` = 0x55 then 0x0F.
   - Two consecutive frames separated by exactly one idle-high cycle.
   - Inputs changed mid-frame do not alter the frame in flight.
4. Pulse `data_valid` with `p_data` = 0xFF at cycle 30 of a frame in progress.
   - Ignored; no second frame is sent.
5. `prescale` = 2.
   - Bits last 4 cycles (clamp).
   - Assert `rest` low during DATA bit 3: `tx_out` = 1 and `busy` = 0 immediately.
   - After release, the next request sends a clean full frame.
6. UART_TX_TWO_STOP_EN build, `prescale` = 8, `par_en` = 1.
   - Stop high for 16 cycles; `busy` lasts 96 cycles.
